// File: rtl/lcd_timing_driver_pkg.sv
// Shared RGB-LCD definitions: default 800x480 timing, coordinate/colour types
// and the RGB565 palette used by the driver and the character-overlay stage.
package lcd_pkg;

    localparam int unsigned H_SYNC_DEF  = 128;
    localparam int unsigned H_BACK_DEF  = 88;
    localparam int unsigned H_DISP_DEF  = 800;
    localparam int unsigned H_FRONT_DEF = 40;
    localparam int unsigned V_SYNC_DEF  = 2;
    localparam int unsigned V_BACK_DEF  = 33;
    localparam int unsigned V_DISP_DEF  = 480;
    localparam int unsigned V_FRONT_DEF = 10;

    localparam int unsigned COORD_W   = 11;
    localparam int unsigned COORD_MAX = 2047;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [15:0]        rgb565_t;

    localparam rgb565_t WHITE   = 16'hFFFF;
    localparam rgb565_t BLACK   = 16'h0000;
    localparam rgb565_t BLUE    = 16'h001F;
    localparam rgb565_t RED     = 16'hF800;
    localparam rgb565_t GREEN   = 16'h07E0;
    localparam rgb565_t YELLOW  = 16'hFFE0;
    localparam rgb565_t CYAN    = 16'h07FF;
    localparam rgb565_t MAGENTA = 16'hF81F;

    // Bar index 0 is the leftmost bar.
    function automatic rgb565_t bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return WHITE;
            3'd1:    return YELLOW;
            3'd2:    return CYAN;
            3'd3:    return GREEN;
            3'd4:    return MAGENTA;
            3'd5:    return RED;
            3'd6:    return BLUE;
            default: return BLACK;
        endcase
    endfunction

endpackage

// File: rtl/lcd_timing_driver_if.sv
// Display-path bus between the timing driver, the overlay stage and the panel.
interface lcd_timing_driver_if;
    import lcd_pkg::*;

    // No back-pressure: the overlay stage must return pixel_data for a
    // coordinate exactly one pclk after that coordinate is presented, every cycle.
    coord_t  pixel_xpos;
    coord_t  pixel_ypos;
    rgb565_t pixel_data;
    logic    lcd_hs;
    logic    lcd_vs;
    logic    lcd_de;
    rgb565_t lcd_rgb;
    logic    lcd_bl;
    logic    frame_start;

    modport master (
        output pixel_xpos, pixel_ypos, lcd_hs, lcd_vs, lcd_de, lcd_rgb, lcd_bl, frame_start,
        input  pixel_data
    );

    modport slave (
        input  pixel_xpos, pixel_ypos, lcd_hs, lcd_vs, lcd_de, lcd_rgb, lcd_bl, frame_start,
        output pixel_data
    );

endinterface

// File: rtl/lcd_colorbar_gen.sv
// Eight equal vertical colour bars from a column coordinate, one cycle registered
// so it lines up with data returned by the overlay stage.
module lcd_colorbar_gen
    import lcd_pkg::*;
#(
    parameter int unsigned H_DISP = H_DISP_DEF
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  coord_t  xpos_i,
    output rgb565_t rgb_o
);

    localparam int unsigned BAR_W = H_DISP / 8;

    rgb565_t rgb_q, rgb_d;

    // Columns past 8*BAR_W (the division remainder) stay black.
    always_comb begin
        rgb_d = BLACK;
        for (int unsigned i = 0; i < 8; i++) begin
            if ((32'(xpos_i) >= i * BAR_W) && (32'(xpos_i) < (i + 1) * BAR_W)) begin
                rgb_d = bar_color(3'(i));
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rgb_q <= BLACK;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign rgb_o = rgb_q;

endmodule

// File: rtl/lcd_timing_driver.sv
// RGB-LCD raster timing, pixel coordinates and aligned RGB565 output.
// Build option: define LCD_TIMING_TEST_PATTERN_EN to compile in the colour-bar source.
module lcd_timing_driver
    import lcd_pkg::*;
#(
    parameter int unsigned H_SYNC  = H_SYNC_DEF,
    parameter int unsigned H_BACK  = H_BACK_DEF,
    parameter int unsigned H_DISP  = H_DISP_DEF,
    parameter int unsigned H_FRONT = H_FRONT_DEF,
    parameter int unsigned V_SYNC  = V_SYNC_DEF,
    parameter int unsigned V_BACK  = V_BACK_DEF,
    parameter int unsigned V_DISP  = V_DISP_DEF,
    parameter int unsigned V_FRONT = V_FRONT_DEF
) (
    input  logic                lcd_pclk,
    input  logic                sys_rst,
    input  logic                pattern_en,
    lcd_timing_driver_if.master lcd
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

    localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
    localparam coord_t H_SYNC_C = coord_t'(H_SYNC);
    localparam coord_t V_SYNC_C = coord_t'(V_SYNC);
    localparam coord_t H_ACT0   = coord_t'(H_SYNC + H_BACK);
    localparam coord_t H_ACT1   = coord_t'(H_SYNC + H_BACK + H_DISP);
    localparam coord_t V_ACT0   = coord_t'(V_SYNC + V_BACK);
    localparam coord_t V_ACT1   = coord_t'(V_SYNC + V_BACK + V_DISP);

    if (H_TOTAL > COORD_MAX || V_TOTAL > COORD_MAX) begin : g_bad_total
        $error("lcd_timing_driver: H_TOTAL/V_TOTAL exceed 11-bit counter range");
    end
    if (H_FRONT < 1) begin : g_bad_front
        $error("lcd_timing_driver: H_FRONT must be at least 1 so DE drops between lines");
    end

    coord_t  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    coord_t  xpos_q, xpos_d, ypos_q, ypos_d;
    logic    req;
    logic    hs1_q, hs1_d, vs1_q, vs1_d, de1_q, de1_d, fs_q, fs_d;
    logic    hs2_q, hs2_d, vs2_q, vs2_d, de2_q, de2_d;
    logic    lcd_hs_q, lcd_hs_d, lcd_vs_q, lcd_vs_d, lcd_de_q, lcd_de_d;
    rgb565_t rgb_q, rgb_d;
    logic    bl_q, bl_d;
    rgb565_t src;

`ifdef LCD_TIMING_TEST_PATTERN_EN
    rgb565_t bar_rgb;

    lcd_colorbar_gen #(.H_DISP(H_DISP)) u_colorbar (
        .clk_i  (lcd_pclk),
        .rst_i  (sys_rst),
        .xpos_i (xpos_q),
        .rgb_o  (bar_rgb)
    );

    assign src = pattern_en ? bar_rgb : lcd.pixel_data;
`else
    logic unused_pattern_en;
    assign unused_pattern_en = pattern_en;
    assign src = lcd.pixel_data;
`endif

    always_comb begin
        h_cnt_d = h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
        end

        req = (h_cnt_q >= H_ACT0) && (h_cnt_q < H_ACT1) &&
              (v_cnt_q >= V_ACT0) && (v_cnt_q < V_ACT1);

        xpos_d = req ? h_cnt_q - H_ACT0 : '0;
        ypos_d = req ? v_cnt_q - V_ACT0 : '0;
        hs1_d  = (h_cnt_q >= H_SYNC_C);
        vs1_d  = (v_cnt_q >= V_SYNC_C);
        de1_d  = req;
        fs_d   = (h_cnt_q == '0) && (v_cnt_q == '0);

        // Controls wait one cycle beside the overlay so they meet its returned data.
        hs2_d    = hs1_q;
        vs2_d    = vs1_q;
        de2_d    = de1_q;
        lcd_hs_d = hs2_q;
        lcd_vs_d = vs2_q;
        lcd_de_d = de2_q;
        rgb_d    = de2_q ? src : BLACK;
        bl_d     = bl_q | fs_d;
    end

    always_ff @(posedge lcd_pclk) begin
        if (sys_rst) begin
            h_cnt_q  <= '0;
            v_cnt_q  <= '0;
            xpos_q   <= '0;
            ypos_q   <= '0;
            hs1_q    <= 1'b1;
            vs1_q    <= 1'b1;
            de1_q    <= 1'b0;
            fs_q     <= 1'b0;
            hs2_q    <= 1'b1;
            vs2_q    <= 1'b1;
            de2_q    <= 1'b0;
            lcd_hs_q <= 1'b1;
            lcd_vs_q <= 1'b1;
            lcd_de_q <= 1'b0;
            rgb_q    <= BLACK;
            bl_q     <= 1'b0;
        end else begin
            h_cnt_q  <= h_cnt_d;
            v_cnt_q  <= v_cnt_d;
            xpos_q   <= xpos_d;
            ypos_q   <= ypos_d;
            hs1_q    <= hs1_d;
            vs1_q    <= vs1_d;
            de1_q    <= de1_d;
            fs_q     <= fs_d;
            hs2_q    <= hs2_d;
            vs2_q    <= vs2_d;
            de2_q    <= de2_d;
            lcd_hs_q <= lcd_hs_d;
            lcd_vs_q <= lcd_vs_d;
            lcd_de_q <= lcd_de_d;
            rgb_q    <= rgb_d;
            bl_q     <= bl_d;
        end
    end

    assign lcd.pixel_xpos  = xpos_q;
    assign lcd.pixel_ypos  = ypos_q;
    assign lcd.lcd_hs      = lcd_hs_q;
    assign lcd.lcd_vs      = lcd_vs_q;
    assign lcd.lcd_de      = lcd_de_q;
    assign lcd.lcd_rgb     = rgb_q;
    assign lcd.lcd_bl      = bl_q;
    assign lcd.frame_start = fs_q;

endmodule

// File: tb/tb_lcd_timing_driver.sv
// Directed bench: a tiny-timing instance and an 800-wide instance with a short frame.
module tb_lcd_timing_driver;
    import lcd_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic pat_a = 1'b0;
    logic pat_b = 1'b1;

    int checks = 0;
    int errors = 0;

`ifdef LCD_TIMING_TEST_PATTERN_EN
    localparam logic [15:0] EXP_X0_Y0   = 16'hFFFF;
    localparam logic [15:0] EXP_X99_Y0  = 16'hFFFF;
    localparam logic [15:0] EXP_X100_Y0 = 16'hFFE0;
    localparam logic [15:0] EXP_X700_Y0 = 16'h0000;
    localparam logic [15:0] EXP_X799_Y0 = 16'h0000;
    localparam logic [15:0] EXP_X0_Y7   = 16'hFFFF;
    localparam logic [15:0] EXP_X799_Y7 = 16'h0000;
`else
    localparam logic [15:0] EXP_X0_Y0   = 16'h0000;
    localparam logic [15:0] EXP_X99_Y0  = 16'h1803;
    localparam logic [15:0] EXP_X100_Y0 = 16'h2004;
    localparam logic [15:0] EXP_X700_Y0 = 16'hE01C;
    localparam logic [15:0] EXP_X799_Y0 = 16'hF81F;
    localparam logic [15:0] EXP_X0_Y7   = 16'h00E0;
    localparam logic [15:0] EXP_X799_Y7 = 16'hF8FF;
`endif

    lcd_timing_driver_if if_a ();
    lcd_timing_driver_if if_b ();

    lcd_timing_driver #(
        .H_SYNC(2), .H_BACK(3), .H_DISP(4), .H_FRONT(1),
        .V_SYNC(1), .V_BACK(1), .V_DISP(2), .V_FRONT(1)
    ) u_dut_a (
        .lcd_pclk   (clk),
        .sys_rst    (rst_a),
        .pattern_en (pat_a),
        .lcd        (if_a)
    );

    lcd_timing_driver #(
        .V_SYNC(2), .V_BACK(3), .V_DISP(8), .V_FRONT(2)
    ) u_dut_b (
        .lcd_pclk   (clk),
        .sys_rst    (rst_b),
        .pattern_en (pat_b),
        .lcd        (if_b)
    );

    // Overlay model: data for a coordinate appears one pclk after it.
    initial begin
        logic [10:0] ax, ay, bx, by;
        if_a.pixel_data = '0;
        if_b.pixel_data = '0;
        forever begin
            @(negedge clk);
            ax = if_a.pixel_xpos;
            ay = if_a.pixel_ypos;
            bx = if_b.pixel_xpos;
            by = if_b.pixel_ypos;
            @(posedge clk);
            #1;
            if_a.pixel_data = {ax[4:0], ay[5:0], ax[4:0]};
            if_b.pixel_data = {bx[4:0], by[5:0], bx[4:0]};
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_reset(input string tag, input logic hs, input logic vs, input logic de,
                               input logic bl, input logic fs, input logic [15:0] rgb,
                               input logic [10:0] x, input logic [10:0] y);
        check({tag, "_hs"}, 32'(hs), 32'd1);
        check({tag, "_vs"}, 32'(vs), 32'd1);
        check({tag, "_de"}, 32'(de), 32'd0);
        check({tag, "_bl"}, 32'(bl), 32'd0);
        check({tag, "_fs"}, 32'(fs), 32'd0);
        check({tag, "_rgb"}, 32'(rgb), 32'd0);
        check({tag, "_x"}, 32'(x), 32'd0);
        check({tag, "_y"}, 32'(y), 32'd0);
    endtask

    initial begin
        int run, last_fall, fs_cnt, de_cnt, de_rises;
        logic prev_de, prev_hs;

        repeat (3) step();
        check_reset("a_rst", if_a.lcd_hs, if_a.lcd_vs, if_a.lcd_de, if_a.lcd_bl,
                    if_a.frame_start, if_a.lcd_rgb, if_a.pixel_xpos, if_a.pixel_ypos);
        rst_a = 1'b0;

        // Small timing: H_TOTAL=10, V_TOTAL=5; outputs lag counters by 3 edges.
        run = 0; last_fall = -1; fs_cnt = 0; de_cnt = 0;
        prev_de = 1'b0; prev_hs = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            step();
            if (if_a.lcd_de) run++;
            if (prev_de && !if_a.lcd_de) begin
                check("a_de_run", 32'(run), 32'd4);
                run = 0;
            end
            if (prev_hs && !if_a.lcd_hs) begin
                if (last_fall >= 0) check("a_hs_period", 32'(n - last_fall), 32'd10);
                last_fall = n;
            end
            if (!if_a.lcd_de) check("a_rgb_idle", 32'(if_a.lcd_rgb), 32'd0);
            fs_cnt += int'(if_a.frame_start);
            de_cnt += int'(if_a.lcd_de);
            case (n)
                1: begin
                    check("a_fs_first", 32'(if_a.frame_start), 32'd1);
                    check("a_bl_on", 32'(if_a.lcd_bl), 32'd1);
                    check("a_hs_n1", 32'(if_a.lcd_hs), 32'd1);
                end
                2: begin
                    check("a_fs_n2", 32'(if_a.frame_start), 32'd0);
                    check("a_hs_n2", 32'(if_a.lcd_hs), 32'd1);
                end
                3: begin
                    check("a_hs_n3", 32'(if_a.lcd_hs), 32'd0);
                    check("a_vs_n3", 32'(if_a.lcd_vs), 32'd0);
                end
                12: check("a_vs_n12", 32'(if_a.lcd_vs), 32'd0);
                13: begin
                    check("a_vs_n13", 32'(if_a.lcd_vs), 32'd1);
                    check("a_hs_n13", 32'(if_a.lcd_hs), 32'd0);
                end
                26: begin
                    check("a_x_n26", 32'(if_a.pixel_xpos), 32'd0);
                    check("a_y_n26", 32'(if_a.pixel_ypos), 32'd0);
                end
                27: check("a_de_n27", 32'(if_a.lcd_de), 32'd0);
                28: begin
                    check("a_de_n28", 32'(if_a.lcd_de), 32'd1);
                    check("a_rgb_x0y0", 32'(if_a.lcd_rgb), 32'h0000);
                end
                29: begin
                    check("a_rgb_x1y0", 32'(if_a.lcd_rgb), 32'h0801);
                    check("a_x_n29", 32'(if_a.pixel_xpos), 32'd3);
                end
                30: check("a_x_n30", 32'(if_a.pixel_xpos), 32'd0);
                31: check("a_de_n31", 32'(if_a.lcd_de), 32'd1);
                32: check("a_de_n32", 32'(if_a.lcd_de), 32'd0);
                38: check("a_rgb_x0y1", 32'(if_a.lcd_rgb), 32'h0020);
                39: begin
                    check("a_x_n39", 32'(if_a.pixel_xpos), 32'd3);
                    check("a_y_n39", 32'(if_a.pixel_ypos), 32'd1);
                end
                41: check("a_rgb_x3y1", 32'(if_a.lcd_rgb), 32'h1823);
                51: check("a_fs_wrap", 32'(if_a.frame_start), 32'd1);
                default: ;
            endcase
            prev_de = if_a.lcd_de;
            prev_hs = if_a.lcd_hs;
        end
        check("a_fs_count", 32'(fs_cnt), 32'd2);
        check("a_de_count", 32'(de_cnt), 32'd8);

        check_reset("b_rst", if_b.lcd_hs, if_b.lcd_vs, if_b.lcd_de, if_b.lcd_bl,
                    if_b.frame_start, if_b.lcd_rgb, if_b.pixel_xpos, if_b.pixel_ypos);
        rst_b = 1'b0;

        // 800-wide timing, V_TOTAL=15: frame of 1056*15 = 15840 clocks.
        fs_cnt = 0; de_cnt = 0; de_rises = 0; prev_de = 1'b0;
        for (int n = 1; n <= 22676; n++) begin
            step();
            if (!if_b.lcd_de) check("b_rgb_idle", 32'(if_b.lcd_rgb), 32'd0);
            if (n <= 15841) begin
                fs_cnt += int'(if_b.frame_start);
                de_cnt += int'(if_b.lcd_de);
                if (!prev_de && if_b.lcd_de) de_rises++;
            end
            case (n)
                5498:  check("b_de_pre", 32'(if_b.lcd_de), 32'd0);
                5499:  begin
                    check("b_de_x0", 32'(if_b.lcd_de), 32'd1);
                    check("b_rgb_x0y0", 32'(if_b.lcd_rgb), 32'(EXP_X0_Y0));
                end
                5598:  check("b_rgb_x99y0", 32'(if_b.lcd_rgb), 32'(EXP_X99_Y0));
                5599:  check("b_rgb_x100y0", 32'(if_b.lcd_rgb), 32'(EXP_X100_Y0));
                6199:  check("b_rgb_x700y0", 32'(if_b.lcd_rgb), 32'(EXP_X700_Y0));
                6298:  begin
                    check("b_de_x799", 32'(if_b.lcd_de), 32'd1);
                    check("b_rgb_x799y0", 32'(if_b.lcd_rgb), 32'(EXP_X799_Y0));
                end
                6299:  check("b_de_post", 32'(if_b.lcd_de), 32'd0);
                12889: begin
                    check("b_x_n12889", 32'(if_b.pixel_xpos), 32'd0);
                    check("b_y_n12889", 32'(if_b.pixel_ypos), 32'd7);
                end
                12891: check("b_rgb_x0y7", 32'(if_b.lcd_rgb), 32'(EXP_X0_Y7));
                13688: begin
                    check("b_x_last", 32'(if_b.pixel_xpos), 32'd799);
                    check("b_y_last", 32'(if_b.pixel_ypos), 32'd7);
                end
                13689: begin
                    check("b_x_after", 32'(if_b.pixel_xpos), 32'd0);
                    check("b_y_after", 32'(if_b.pixel_ypos), 32'd0);
                end
                13690: check("b_rgb_x799y7", 32'(if_b.lcd_rgb), 32'(EXP_X799_Y7));
                15840: check("b_fs_pre_wrap", 32'(if_b.frame_start), 32'd0);
                15841: check("b_fs_wrap", 32'(if_b.frame_start), 32'd1);
                22676: check("b_de_before_rst", 32'(if_b.lcd_de), 32'd1);
                default: ;
            endcase
            prev_de = if_b.lcd_de;
        end
        check("b_fs_count", 32'(fs_cnt), 32'd2);
        check("b_de_count", 32'(de_cnt), 32'd6400);
        check("b_line_count", 32'(de_rises), 32'd8);

        // One-cycle reset mid-frame at v_cnt=6, h_cnt=500.
        rst_b = 1'b1;
        step();
        check_reset("b_midrst", if_b.lcd_hs, if_b.lcd_vs, if_b.lcd_de, if_b.lcd_bl,
                    if_b.frame_start, if_b.lcd_rgb, if_b.pixel_xpos, if_b.pixel_ypos);
        rst_b = 1'b0;
        step();
        check("b_fs_after_rst", 32'(if_b.frame_start), 32'd1);
        check("b_bl_after_rst", 32'(if_b.lcd_bl), 32'd1);
        step();
        check("b_hs_after_rst_n2", 32'(if_b.lcd_hs), 32'd1);
        step();
        check("b_hs_after_rst_n3", 32'(if_b.lcd_hs), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
